bcd_digit_counter_cc: RTL and testbench
=======================================

Name: bcd_digit_counter_cc

Overview:
- Self-running single-digit demo for a common-cathode 7-segment display.
- A clock-enable divider produces a tick every 1/TICK_HZ s. The tick advances a free-running 4-bit counter (0..15, wraps).
- The counter value is decoded to segments, with the decimal point driven by counter bit 0.
- Sits directly at the FPGA pins for one digit; everything runs in a single clock domain (no derived clocks).

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 2, counter advance rate in Hz. DIV = CLK_HZ/TICK_HZ clock cycles per tick; DIV must be >= 2 (elaboration error otherwise).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-high (asserted = 1). The name is kept per codebase.
- Segments  output  7  segment drive, active-high. Bit0=a, bit1=b, … bit6=g.
- dp  output  1  decimal point, active-high.
- SEL7  output  1  digit cathode select, active-low; constant 0 (digit always enabled).
- bcd_out  output  4  current counter value (observability).
- tick  output  1  one-cycle pulse marking each counter advance.

Behaviour:
- Reset (rst_n=1, asynchronous):
  - divider count = 0, counter = 0, tick = 0.
  - Therefore Segments = 7'h3F, dp = 0, bcd_out = 0, SEL7 = 0.
  - Holds while asserted.
- Divider:
  - Register div_cnt, width clog2(DIV).
  - Increments each clk edge; on reaching DIV-1 it returns to 0 and tick is registered high for exactly that one next cycle.
  - Tick period is exactly DIV cycles. The first tick is asserted DIV cycles after reset release.
- Counter:
  - 4-bit register. On the clk edge where tick=1, increments by 1.
  - 15 -> 0 wrap, no saturation, no carry output.
- Decode (combinational from counter register; zero added latency, outputs change in the cycle after tick):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, gfedcba).
  - Codes 10..15 are invalid BCD: Segments = 7'h00 (blank).
- dp = counter[0] for all 16 values, including blank codes.
- SEL7 is tied 0 regardless of reset.
- Reset mid-count: everything returns to its reset value at once, and the divider phase restarts from 0.

Decomposition:
- Package bcd7_pkg:
  - SEG_0..SEG_9 constants and SEG_BLANK = 7'h00.
  - Segment bit-index constants (SEG_A..SEG_G).
  - A function for divider width.
- One natural sub-module: bcd_to_7seg_cc, a purely combinational 4-bit to 7-bit decoder including the blank rule.
- Divider and counter stay in the top.

Test Plan (CLK_HZ=20, TICK_HZ=2 -> DIV=10):
- Reset held 5 cycles, then released -> Segments=3F, dp=0, SEL7=0, bcd_out=0 throughout and for 9 further cycles.
- Free run: tick high for exactly 1 cycle every 10 cycles; bcd_out advances 0->1->2… one cycle after each tick.
- Sweep 0..9 -> Segments 3F,06,5B,4F,66,6D,7D,07,7F,6F; dp alternates 0,1,0,1…
- Values 10..15 -> Segments=00 each; dp = 0,1,0,1,0,1.
- Wrap: at bcd_out=15 the next tick gives bcd_out=0, Segments=3F, dp=0.
- Assert rst_n asynchronously (between clk edges) at bcd_out=7 -> outputs go immediately to 3F/0/0 and tick=0; after release the first tick comes 10 cycles later.

Source files
------------

// File: rtl/bcd7_pkg.sv
// rtl/bcd7_pkg.sv - segment codes, segment bit indices and divider width helper
package bcd7_pkg;

  // Common-cathode, active-high segment codes, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Bit positions of each segment within the 7-bit drive vector
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Width of a counter holding 0..div-1; never less than one bit
  function automatic int div_width(input int div);
    int w;
    w = $clog2(div);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_to_7seg_cc.sv
// rtl/bcd_to_7seg_cc.sv - combinational 4-bit to common-cathode 7-segment decoder
module bcd_to_7seg_cc
  import bcd7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Digits 0..9 map to their glyphs; 10..15 are not BCD and stay blank
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_digit_counter_cc.sv
// rtl/bcd_digit_counter_cc.sv - self-running single-digit 7-segment counter demo
module bcd_digit_counter_cc
  import bcd7_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [6:0] Segments,
  output logic       dp,
  output logic       SEL7,
  output logic [3:0] bcd_out,
  output logic       tick
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = div_width(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("bcd_digit_counter_cc: CLK_HZ/TICK_HZ must be at least 2");
    end
  endgenerate

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick_q, tick_d;
  logic [3:0]       cnt_q, cnt_d;

  // Divider wraps at DIV-1 and flags the wrap as a one-cycle tick;
  // the counter advances on the edge that sees the registered tick
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_ONE;
    tick_d    = 1'b0;
    cnt_d     = cnt_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      tick_d    = 1'b1;
    end
    if (tick_q) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // State registers; rst_n is active-high despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
      cnt_q     <= 4'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      cnt_q     <= cnt_d;
    end
  end

  bcd_to_7seg_cc u_dec (
    .bcd (cnt_q),
    .seg (Segments)
  );

  assign dp      = cnt_q[0];
  assign SEL7    = 1'b0;
  assign bcd_out = cnt_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_bcd_digit_counter_cc.sv
// tb/tb_bcd_digit_counter_cc.sv - directed self-checking bench for bcd_digit_counter_cc
module tb_bcd_digit_counter_cc;

  logic       clk;
  logic       rst_n;
  logic [6:0] Segments;
  logic       dp;
  logic       SEL7;
  logic [3:0] bcd_out;
  logic       tick;

  int checks;
  int failures;
  int n;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  bcd_digit_counter_cc #(
    .CLK_HZ  (20),
    .TICK_HZ (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Segments (Segments),
    .dp       (dp),
    .SEL7     (SEL7),
    .bcd_out  (bcd_out),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_seg"},  32'(Segments), 32'h3F);
    check_eq({tag, "_dp"},   32'(dp),       32'h0);
    check_eq({tag, "_sel"},  32'(SEL7),     32'h0);
    check_eq({tag, "_bcd"},  32'(bcd_out),  32'h0);
    check_eq({tag, "_tick"}, 32'(tick),     32'h0);
  endtask

  // n = rising edges since reset release. Ticks appear after edges 10,20,...
  // and the digit advances one edge later: value = (n-1)/10 mod 16.
  task automatic run_and_check(input int cycles);
    logic [3:0] exp_bcd;
    logic       exp_tick;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      exp_tick = (n % 10 == 0);
      exp_bcd  = 4'(((n - 1) / 10) % 16);
      check_eq("tick", 32'(tick),     32'(exp_tick));
      check_eq("bcd",  32'(bcd_out),  32'(exp_bcd));
      check_eq("seg",  32'(Segments), 32'(seg_tab[exp_bcd]));
      check_eq("dp",   32'(dp),       32'(exp_bcd[0]));
      check_eq("sel",  32'(SEL7),     32'h0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    n        = 0;
    rst_n    = 1'b1;

    // Reset held for 5 cycles; outputs sit at reset values throughout
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_reset_outputs("rst_hold");
    end

    // Release, then free run through 0..15, wrap, and on to digit 7 with tick high
    rst_n = 1'b0;
    n     = 0;
    run_and_check(240);
    check_eq("pre_rst_tick", 32'(tick),    32'h1);
    check_eq("pre_rst_bcd",  32'(bcd_out), 32'h7);

    // Asynchronous reset between edges must clear everything at once
    #2;
    rst_n = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    check_reset_outputs("async_rst_hold");
    @(negedge clk);

    // After release the divider phase restarts: first tick 10 edges later
    rst_n = 1'b0;
    n     = 0;
    run_and_check(22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
